// File: rtl/dcache_pkg.sv
// dcache_pkg: controller states, default cache geometry and the byte-merge helper
// shared by the write-hit and refill-merge paths of dcache_wb_controller.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_FILL,
        S_DONE
    } state_e;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_WORD_BYTES  = 4;
    localparam int DEF_BLOCK_BYTES = 16;
    localparam int OFFSET_W        = $clog2(DEF_BLOCK_BYTES);
    localparam int WORD_OFF_W      = $clog2(DEF_BLOCK_BYTES / DEF_WORD_BYTES);
    localparam int BLOCK_BITS      = 8 * DEF_BLOCK_BYTES;
    localparam int WORD_BITS       = 8 * DEF_WORD_BYTES;

    // The helper works on the widest supported geometry; callers cast to their own widths.
    localparam int MAX_BLOCK_BYTES = 256;
    localparam int MAX_WORD_BYTES  = 64;

    function automatic logic [8*MAX_BLOCK_BYTES-1:0] merge_word(
        input logic [8*MAX_BLOCK_BYTES-1:0] blk,
        input logic [8*MAX_WORD_BYTES-1:0]  data,
        input logic [MAX_WORD_BYTES-1:0]    be,
        input int                           word_bytes,
        input int                           word_idx
    );
        logic [8*MAX_BLOCK_BYTES-1:0] r;
        r = blk;
        for (int b = 0; b < MAX_WORD_BYTES; b++)
            if (b < word_bytes && be[b])
                r[8*(word_idx*word_bytes + b) +: 8] = data[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dcache_wb_controller_watchdog.sv
// dcache_mem_watchdog: counts cycles spent waiting on memory and pulses timeout_o on the
// TIMEOUT-th cycle; TIMEOUT = 0 disables it.
module dcache_mem_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int            CW    = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active;

    assign active    = en_i && TIMEOUT != 0;
    assign cnt_d     = clear_i ? '0 : active ? cnt_q + CW'(1) : cnt_q;
    assign timeout_o = active && cnt_q == LIMIT;

    always_ff @(posedge clock_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dcache_wb_controller.sv
// dcache_wb_controller: write-back, write-allocate direct-mapped L1 data-cache controller.
// Define DCACHE_STATS_EN to build the hit/miss/writeback counters; otherwise they read 0.
module dcache_wb_controller
    import dcache_pkg::*;
#(
    parameter int  ADDR_W      = DEF_ADDR_W,
    parameter int  WORD_BYTES  = DEF_WORD_BYTES,
    parameter int  BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int  INDEX_W     = 6,
    parameter int  MEM_TIMEOUT = 1024,
    localparam int OFF_W       = $clog2(BLOCK_BYTES),
    localparam int TAG_W       = ADDR_W - INDEX_W - OFF_W,
    localparam int BA_W        = ADDR_W - OFF_W,
    localparam int WB          = 8 * WORD_BYTES,
    localparam int BB          = 8 * BLOCK_BYTES
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   ren_i,
    input  logic                   wen_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [WORD_BYTES-1:0]  byteSelectVector_i,
    input  logic [WB-1:0]          din_i,
    input  logic                   cacheHit_i,
    input  logic                   cacheDirtyBit_i,
    input  logic [TAG_W-1:0]       cacheVictimTag_i,
    input  logic [BB-1:0]          cacheDout_i,
    input  logic                   memReadReady_i,
    input  logic                   memWriteDone_i,
    input  logic [BB-1:0]          memDout_i,
    output logic                   stall_o,
    output logic [WB-1:0]          dout_o,
    output logic [BA_W-1:0]        BlockAddr_o,
    output logic                   cacheEn_o,
    output logic                   cacheWen_o,
    output logic                   cacheFullWen_o,
    output logic                   cacheSetDirty_o,
    output logic [BLOCK_BYTES-1:0] cacheBytesAccess_o,
    output logic [BB-1:0]          cacheDin_o,
    output logic                   memRen_o,
    output logic                   memWen_o,
    output logic [BB-1:0]          memDin_o,
    output logic                   memErr_o,
    output logic [31:0]            hitCount_o,
    output logic [31:0]            missCount_o,
    output logic [31:0]            wbCount_o
);

    localparam int MB = 8 * MAX_BLOCK_BYTES;
    localparam int MW = 8 * MAX_WORD_BYTES;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wr_q, err_q;
    logic [WB-1:0]         din_q;
    logic [WORD_BYTES-1:0] be_q;
    logic [TAG_W-1:0]      vtag_q;
    logic [BB-1:0]         vblk_q, fill_q;
    logic                  req, hit, miss, timeout, wd_en, wd_clear;
    int                    widx, widx_q;

    // Asserting both ren and wen is deliberately a no-op, and reset masks any request.
    assign req      = (ren_i ^ wen_i) && !reset_i;
    assign hit      = state_q == S_IDLE && req && cacheHit_i;
    assign miss     = state_q == S_IDLE && req && !cacheHit_i;
    assign widx     = int'(addr_i[OFF_W-1:0]) / WORD_BYTES;
    assign widx_q   = int'(addr_q[OFF_W-1:0]) / WORD_BYTES;
    assign wd_en    = state_q == S_WRITEBACK || state_q == S_REFILL;
    assign wd_clear = (state_d == S_WRITEBACK || state_d == S_REFILL) && state_d != state_q;
    assign memErr_o = err_q;

    dcache_mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d            = state_q;
        stall_o            = 1'b0;
        dout_o             = '0;
        BlockAddr_o        = addr_i[ADDR_W-1:OFF_W];
        cacheEn_o          = 1'b0;
        cacheWen_o         = 1'b0;
        cacheFullWen_o     = 1'b0;
        cacheSetDirty_o    = 1'b0;
        cacheBytesAccess_o = '0;
        cacheDin_o         = '0;
        memRen_o           = 1'b0;
        memWen_o           = 1'b0;
        memDin_o           = '0;
        case (state_q)
            S_IDLE: begin
                state_d            = miss ? (cacheDirtyBit_i ? S_WRITEBACK : S_REFILL) : S_IDLE;
                stall_o            = miss;
                cacheEn_o          = hit;
                cacheWen_o         = hit && wen_i;
                cacheSetDirty_o    = hit && wen_i;
                cacheBytesAccess_o = hit && wen_i ? BLOCK_BYTES'(byteSelectVector_i) << (WORD_BYTES * widx) : '0;
                cacheDin_o         = hit && wen_i ? BB'(merge_word('0, MW'(din_i), '1, WORD_BYTES, widx)) : '0;
                dout_o             = hit && ren_i ? WB'(cacheDout_i >> (WB * widx)) : '0;
            end
            S_WRITEBACK: begin
                state_d     = timeout ? S_IDLE : memWriteDone_i ? S_REFILL : S_WRITEBACK;
                stall_o     = 1'b1;
                memWen_o    = 1'b1;
                BlockAddr_o = {vtag_q, addr_q[OFF_W +: INDEX_W]};
                memDin_o    = vblk_q;
            end
            S_REFILL: begin
                state_d     = timeout ? S_IDLE : memReadReady_i ? S_FILL : S_REFILL;
                stall_o     = 1'b1;
                memRen_o    = 1'b1;
                BlockAddr_o = addr_q[ADDR_W-1:OFF_W];
            end
            S_FILL: begin
                state_d            = S_DONE;
                stall_o            = 1'b1;
                BlockAddr_o        = addr_q[ADDR_W-1:OFF_W];
                cacheEn_o          = 1'b1;
                cacheWen_o         = 1'b1;
                cacheFullWen_o     = 1'b1;
                cacheBytesAccess_o = '1;
                cacheDin_o         = fill_q;
                cacheSetDirty_o    = wr_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
                dout_o  = WB'(fill_q >> (WB * widx_q));
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            be_q    <= '0;
            vtag_q  <= '0;
            vblk_q  <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss) begin
                addr_q <= addr_i;
                wr_q   <= wen_i;
                din_q  <= din_i;
                be_q   <= byteSelectVector_i;
                vtag_q <= cacheVictimTag_i;
                vblk_q <= cacheDout_i;
            end
            if (state_q == S_REFILL && memReadReady_i && !timeout)
                fill_q <= wr_q ? BB'(merge_word(MB'(memDout_i), MW'(din_q), MAX_WORD_BYTES'(be_q), WORD_BYTES, widx_q))
                               : memDout_i;
            if (timeout)
                err_q <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q, wbs_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            if (hit && hits_q != '1)
                hits_q <= hits_q + 32'd1;
            if (miss && misses_q != '1)
                misses_q <= misses_q + 32'd1;
            if (miss && cacheDirtyBit_i && wbs_q != '1)
                wbs_q <= wbs_q + 32'd1;
        end
    end

    assign hitCount_o  = hits_q;
    assign missCount_o = misses_q;
    assign wbCount_o   = wbs_q;
`else
    assign hitCount_o  = '0;
    assign missCount_o = '0;
    assign wbCount_o   = '0;
`endif

endmodule

// File: tb/tb_dcache_wb_controller.sv
// tb_dcache_wb_controller: directed checks of hits, clean/dirty misses, timeout, reset and counters.
module tb_dcache_wb_controller;

    logic         clock = 1'b0;
    logic         reset, ren, wen, hit, dirty, mrr, mwd;
    logic [31:0]  addr, din, dout, hits, misses, wbs;
    logic [3:0]   bsv;
    logic [21:0]  vtag;
    logic [127:0] cdout, mdout, cdin, mdin;
    logic         stall, cen, cwen, cfull, cdirty, memRen, memWen, memErr;
    logic [27:0]  baddr;
    logic [15:0]  cbytes;
    int           n_tests = 0;
    int           n_fail = 0;

    localparam logic [127:0] HIT_BLK = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
    localparam logic [127:0] M1      = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam logic [127:0] M2      = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] M2_MRG  = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hCAFEA1A1, 32'hA0A0A0A0};
    localparam logic [127:0] VB      = 128'h0123456789ABCDEF_FEDCBA9876543210;
`ifdef DCACHE_STATS_EN
    localparam logic [31:0] EH = 32'd3, EM = 32'd2, EW = 32'd1;
`else
    localparam logic [31:0] EH = 32'd0, EM = 32'd0, EW = 32'd0;
`endif

    always #5 clock = ~clock;

    dcache_wb_controller #(.MEM_TIMEOUT(8)) dut (
        .clock_i            (clock),
        .reset_i            (reset),
        .ren_i              (ren),
        .wen_i              (wen),
        .addr_i             (addr),
        .byteSelectVector_i (bsv),
        .din_i              (din),
        .cacheHit_i         (hit),
        .cacheDirtyBit_i    (dirty),
        .cacheVictimTag_i   (vtag),
        .cacheDout_i        (cdout),
        .memReadReady_i     (mrr),
        .memWriteDone_i     (mwd),
        .memDout_i          (mdout),
        .stall_o            (stall),
        .dout_o             (dout),
        .BlockAddr_o        (baddr),
        .cacheEn_o          (cen),
        .cacheWen_o         (cwen),
        .cacheFullWen_o     (cfull),
        .cacheSetDirty_o    (cdirty),
        .cacheBytesAccess_o (cbytes),
        .cacheDin_o         (cdin),
        .memRen_o           (memRen),
        .memWen_o           (memWen),
        .memDin_o           (mdin),
        .memErr_o           (memErr),
        .hitCount_o         (hits),
        .missCount_o        (misses),
        .wbCount_o          (wbs)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task step;
        @(posedge clock);
        #1;
    endtask

    task settle;
        #2;
    endtask

    initial begin
        {reset, ren, wen, hit, dirty, mrr, mwd, addr, din, bsv, vtag, cdout, mdout} = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        settle();
        check("rst_stall", stall, 0);
        check("rst_memren", memRen, 0);
        check("rst_memwen", memWen, 0);
        check("rst_memerr", memErr, 0);
        check("rst_hits", hits, 0);

        step();
        ren = 1; addr = 32'h104; hit = 1; cdout = HIT_BLK;
        settle();
        check("rdhit_dout", dout, 32'hDEADBEEF);
        check("rdhit_stall", stall, 0);
        check("rdhit_mem", {memRen, memWen}, 0);
        check("rdhit_baddr", baddr, 28'h10);

        step();
        ren = 0; wen = 1; addr = 32'h108; bsv = 4'b0011; din = 32'h0000ABCD;
        settle();
        check("wrhit_bytes", cbytes, 16'h0300);
        check("wrhit_dirty", cdirty, 1);
        check("wrhit_wen", {cen, cwen}, 2'b11);
        check("wrhit_stall", stall, 0);
        check("wrhit_din", cdin, 128'h00000000_0000ABCD_00000000_00000000);

        step();
        ren = 1; wen = 1; hit = 0;
        settle();
        check("both_stall", stall, 0);
        check("both_cen", cen, 0);

        step();
        wen = 0; addr = 32'h204; dirty = 0;
        settle();
        check("miss_stall", stall, 1);
        step();
        settle();
        check("refill_memren", memRen, 1);
        check("refill_baddr", baddr, 28'h20);
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            check("refill_wait", {stall, memRen}, 2'b11);
        end
        step();
        mrr = 1; mdout = M1;
        settle();
        check("refill_ready_memren", memRen, 1);
        step();
        mrr = 0;
        settle();
        check("fill_full", {cen, cwen, cfull}, 3'b111);
        check("fill_bytes", cbytes, 16'hFFFF);
        check("fill_din", cdin, M1);
        check("fill_dirty", cdirty, 0);
        check("fill_stall_memren", {stall, memRen}, 2'b10);
        step();
        settle();
        check("done_stall", stall, 0);
        check("done_dout", dout, 32'hB1B1B1B1);
        check("done_cen", cen, 0);
        step();
        ren = 0;
        settle();
        check("idle_stall", stall, 0);

        wen = 1; addr = 32'h1434; bsv = 4'b1100; din = 32'hCAFE1234;
        dirty = 1; vtag = 22'h12; cdout = VB;
        settle();
        check("wmiss_stall", stall, 1);
        step();
        cdout = '0;
        settle();
        check("wb_memwen", {memWen, memRen}, 2'b10);
        check("wb_baddr", baddr, 28'h483);
        check("wb_memdin", mdin, VB);
        step();
        step();
        mwd = 1;
        settle();
        check("wb_done_memwen", memWen, 1);
        step();
        mwd = 0;
        settle();
        check("wb_refill_mem", {memRen, memWen}, 2'b10);
        check("wb_refill_baddr", baddr, 28'h143);
        mrr = 1; mdout = M2;
        step();
        mrr = 0;
        settle();
        check("wfill_din", cdin, M2_MRG);
        check("wfill_dirty", {cfull, cdirty}, 2'b11);
        step();
        settle();
        check("wdone", {stall, dout}, {1'b0, 32'hCAFEA1A1});
        step();
        wen = 0; dirty = 0; mrr = 1;
        settle();
        check("stray_ready", {stall, memRen}, 0);
        step();
        mrr = 0; ren = 1; hit = 1; addr = 32'h104; cdout = HIT_BLK;
        settle();
        check("rdhit2_dout", dout, 32'hDEADBEEF);
        step();
        ren = 0; hit = 0;
        settle();
        check("stat_hits", hits, EH);
        check("stat_misses", misses, EM);
        check("stat_wbs", wbs, EW);

        ren = 1; addr = 32'h300;
        step();
        for (int i = 0; i < 8; i++) begin
            settle();
            check("to_memren", memRen, 1);
            if (i == 7) ren = 0;
            step();
        end
        settle();
        check("to_err", memErr, 1);
        check("to_memren_drop", {memRen, stall}, 0);
        step();
        step();
        settle();
        check("to_err_sticky", memErr, 1);
        reset = 1;
        step();
        reset = 0;
        settle();
        check("to_err_cleared", memErr, 0);

        step();
        ren = 1; addr = 32'h104; dirty = 1; vtag = 22'h7;
        settle();
        step();
        settle();
        check("rstwb_memwen", memWen, 1);
        reset = 1; ren = 0;
        step();
        settle();
        check("rstwb_drop", {memWen, memRen, stall}, 0);
        check("rstwb_stats", {hits, misses, wbs}, 0);
        reset = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
